// File: rtl/npu_result_axis_packer_if.sv
// AXI-Stream result channel of the NPU readout packer.
// Two 8-bit lanes per beat with byte strobes and end-of-pass marker.
interface npu_result_axis_packer_if #(
   parameter int DATA_WIDTH = 16
);
   logic                    tvalid;
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic                    tlast;
   logic                    tready;

   modport master (
      output tvalid, tdata, tstrb, tlast,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tstrb, tlast,
      output tready
   );
endinterface

// File: rtl/npu_result_axis_packer.sv
// Packs 6-bit ADC codes two-per-beat into a FIFO-buffered AXI-Stream master.
// Optional PACKER_OFFSET_SUB_EN: offset-subtract stage (offset latched at start).
module npu_result_axis_packer #(
   parameter int AXIS_DATA_WIDTH = 16,
   parameter int ADC_WIDTH       = 6,
   parameter int MAX_NUM_BL      = 256,
   parameter int FIFO_DEPTH      = 16,
   localparam int NBW = $clog2(MAX_NUM_BL + 1),
   localparam int AW  = $clog2(FIFO_DEPTH),
   localparam int LW  = AXIS_DATA_WIDTH / 2,
   localparam int EW  = AXIS_DATA_WIDTH + 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NBW-1:0]       num_bl,
`ifdef PACKER_OFFSET_SUB_EN
   input  logic [ADC_WIDTH-1:0] offset,
`endif
   input  logic                 sample_valid,
   input  logic [ADC_WIDTH-1:0] sample_data,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow,
   npu_result_axis_packer_if.master m00_axis
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_PEND,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t         state, state_nx;
   logic [NBW-1:0] n_q, cnt_q;
   logic [LW-1:0]  lane0_q;
   logic           pk_valid;
   logic [LW-1:0]  pk_code;
   logic           last_code;

   logic           push, pop, accept, drop;
   logic [EW-1:0]  push_word, head;
   logic [EW-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           full, empty;

`ifdef PACKER_OFFSET_SUB_EN
   logic [ADC_WIDTH-1:0] off_q, sub;
   logic                 pk_valid_q;
   logic [LW-1:0]        pk_code_q;

   assign sub = (sample_data > off_q) ? sample_data - off_q : '0;

   // Pipe stage only admits codes while a pass is running.
   always_ff @(posedge clk) begin
      if (reset) begin
         off_q      <= '0;
         pk_valid_q <= 1'b0;
         pk_code_q  <= '0;
      end else begin
         pk_valid_q <= sample_valid && (state == S_RUN);
         pk_code_q  <= LW'(sub);
         if (state == S_IDLE && start)
            off_q <= offset;
      end
   end

   assign pk_valid = pk_valid_q;
   assign pk_code  = pk_code_q;
`else
   assign pk_valid = sample_valid;
   assign pk_code  = LW'(sample_data);
`endif

   assign last_code = (cnt_q + NBW'(1)) == n_q;

   assign full   = count == (AW+1)'(FIFO_DEPTH);
   assign empty  = count == '0;
   assign pop    = !empty && m00_axis.tready;
   // A full FIFO still takes a beat when the head leaves in the same cycle.
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;

   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr] <= push_word;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (accept && !pop)
            count <= count + 1'b1;
         else if (!accept && pop)
            count <= count - 1'b1;
      end
   end

   assign head            = mem[rd_ptr];
   assign m00_axis.tvalid = !empty;
   assign m00_axis.tdata  = empty ? '0 : head[AXIS_DATA_WIDTH-1:0];
   assign m00_axis.tstrb  = empty ? '0 : head[AXIS_DATA_WIDTH+1:AXIS_DATA_WIDTH];
   assign m00_axis.tlast  = empty ? 1'b0 : head[EW-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         n_q      <= '0;
         cnt_q    <= '0;
         lane0_q  <= '0;
         overflow <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && start) begin
            n_q      <= num_bl;
            cnt_q    <= '0;
            overflow <= 1'b0;
         end else if (state == S_RUN && pk_valid) begin
            cnt_q <= cnt_q + NBW'(1);
            if (!cnt_q[0])
               lane0_q <= pk_code;
         end
         if (drop)
            overflow <= 1'b1;
      end
   end

   always_comb begin
      state_nx  = state;
      push      = 1'b0;
      push_word = '0;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start)
               state_nx = (num_bl == '0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (pk_valid) begin
               if (cnt_q[0]) begin
                  push      = 1'b1;
                  push_word = {last_code, 2'b11, pk_code, lane0_q};
               end else if (last_code) begin
                  push      = 1'b1;
                  push_word = {1'b1, 2'b01, {LW{1'b0}}, pk_code};
               end
               if (last_code)
                  state_nx = accept ? S_DRAIN : S_PEND;
            end
         end
         S_PEND: begin
            busy      = 1'b1;
            push      = 1'b1;
            push_word = {1'b1, 2'b00, {AXIS_DATA_WIDTH{1'b0}}};
            if (accept)
               state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (pop && m00_axis.tlast)
               state_nx = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule
